seq_ctrl: RTL and testbench
===========================

Name: seq_ctrl

Overview:
- Run controller for the 64-bit Fibonacci-style sequence datapath.
- Accepts a configuration: two seed terms and a term count.
- Loads the term generator, steps it once per accepted output, and streams the terms out over a valid/ready interface.
- Stops on count reached, on abort, or on 64-bit overflow.
- Sits between the register/config interface and any downstream consumer of the sequence terms.

Parameters:
- DATA_W, 64, width of a sequence term.
- CNT_W, 8, width of the term count and term index.

Ports:
- clk  in  1  single clock; all state is updated on its rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets, reset=1 runs).
- start  in  1  1-cycle run request; sampled only in IDLE, DONE or ERR.
- abort  in  1  ends the current run; returns to IDLE.
- cfg_seed0  in  DATA_W  term 0; captured when start is accepted.
- cfg_seed1  in  DATA_W  term 1; captured when start is accepted.
- cfg_count  in  CNT_W  number of terms to emit; captured when start is accepted.
- out_valid  out  1  out_data holds a term.
- out_ready  in  1  consumer accepts the term.
- out_data  out  DATA_W  current term.
- out_idx  out  CNT_W  index of the current term, 0-based.
- busy  out  1  high in LOAD and RUN.
- done  out  1  1-cycle pulse when cfg_count terms have been accepted.
- err_ovf  out  1  sticky overflow flag; cleared by the next accepted start.

Behaviour:
- States: IDLE, LOAD, RUN, DONE, ERR.
- Reset values: state=IDLE, all outputs 0, internal a/b/idx/count all 0, overflow flags 0.
- IDLE, DONE, ERR with start=1:
  - Capture the config; a<=seed0, b<=seed1; clear both overflow flags, idx and err_ovf.
  - Go to LOAD.
- LOAD (1 cycle):
  - If count==0: pulse done, go to DONE.
  - Otherwise go to RUN.
- First out_valid appears 2 cycles after the edge at which start is sampled.
- RUN:
  - If the flag on a is set: set err_ovf, drop out_valid, go to ERR.
  - Otherwise out_valid=1, out_data=a, out_idx=idx.
- Handshake:
  - A term transfers on any edge with out_valid&&out_ready.
  - While out_ready=0: out_data and out_idx stay stable and out_valid stays high.
- On each transfer:
  - a<=b; b<=a+b (DATA_W bits).
  - The flag on a takes the flag on b.
  - The flag on b <= carry out of a+b, OR the flag on a, OR the flag on b.
  - idx<=idx+1.
- Transfer of term count-1: drop out_valid, pulse done for 1 cycle, go to DONE. No extra generator step is observable.
- Overflow only terminates the run when an unrepresentable term would be emitted. Carries in terms beyond count are ignored.
- abort in LOAD or RUN:
  - Go to IDLE on the next edge; out_valid falls; no done pulse; err_ovf is unchanged.
  - abort and a simultaneous transfer: the transfer counts, then abort wins.
- start while busy is ignored. start together with abort in any state: abort wins, start is ignored.
- DONE and ERR are held until start, which re-runs directly.
- Asserting reset mid-run returns to the reset values immediately, asynchronously, with no done pulse.
- Arithmetic is unsigned modulo 2^DATA_W; the overflow flag is the only overflow indication.
- idx wraps only if count is 2^CNT_W, which is impossible; the maximum count is 2^CNT_W-1.

Optional Feature:
- Macro SEQ_CTRL_PERF_EN.
- Defined:
  - Adds output stall_cnt (32 bits): cycles in RUN with out_valid=1 and out_ready=0.
  - Cleared by reset and by an accepted start; saturates at all-ones.
- Not defined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Package seq_pkg holds:
  - state encoding constants: IDLE=0, LOAD=1, RUN=2, DONE=3, ERR=4, 3 bits;
  - the DATA_W and CNT_W defaults.
- One sub-module, seq_term_gen:
  - holds a, b and the two overflow flags;
  - controls: load (with seeds), step;
  - outputs: a, flag on a.
- seq_ctrl holds the FSM, idx/count and the handshake.

Test Plan:
- Basic run: seeds 0,1; count 10; out_ready=1.
  - out_data 0,1,1,2,3,5,8,13,21,34 on idx 0..9, one per cycle.
  - First valid 2 cycles after start; one done pulse; busy falls.
- Overflow: seeds 0,1; count 100.
  - 94 terms emitted, idx 0..93; last is 12200160415121876738.
  - Then err_ovf=1, state ERR, no done.
  - A following start clears err_ovf.
- Backpressure: seeds 5,7; count 4; out_ready low for 5 cycles at idx 1.
  - out_data=7, idx=1 held stable.
  - Full sequence 5,7,12,19; stall_cnt=5 when SEQ_CTRL_PERF_EN is defined.
- Zero count and busy-start: count 0 gives a done pulse 2 cycles after start and never raises out_valid. start during RUN is ignored.
- Abort: abort at idx 3 of a count-10 run → IDLE next cycle, out_valid=0, no done. abort+start in the same cycle → start ignored.
- Reset mid-run: reset=0 during RUN at idx 4 → all outputs 0 immediately. Release, then start again → sequence restarts from idx 0.

Source files
------------

// File: rtl/seq_pkg.sv
// ============================================================================
//  Module   : seq_pkg
//  Brief    : Shared state encoding and width defaults for the sequence block.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

    localparam int c_def_data_w = 64;
    localparam int c_def_cnt_w  = 8;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_load = 3'd1;
    localparam logic [2:0] c_st_run  = 3'd2;
    localparam logic [2:0] c_st_done = 3'd3;
    localparam logic [2:0] c_st_err  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/seq_term_gen.sv
// ============================================================================
//  Module   : seq_term_gen
//  Brief    : Fibonacci-style term pair (a, b) with per-term overflow flags.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module seq_term_gen
    import seq_pkg::*;
#(
    parameter int DATA_W = c_def_data_w
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [DATA_W-1:0] i_seed0,
    input  logic [DATA_W-1:0] i_seed1,
    output logic [DATA_W-1:0] o_a,
    output logic              o_a_ovf
);

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_a_ovf;
    logic              r_b_ovf;
    logic [DATA_W:0]   w_sum;

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};

    // Once a term is unrepresentable, every later term is too, so flags stick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_a_ovf <= 1'b0;
            r_b_ovf <= 1'b0;
        end else if (i_load) begin
            r_a     <= i_seed0;
            r_b     <= i_seed1;
            r_a_ovf <= 1'b0;
            r_b_ovf <= 1'b0;
        end else if (i_step) begin
            r_a     <= r_b;
            r_b     <= w_sum[DATA_W-1:0];
            r_a_ovf <= r_b_ovf;
            r_b_ovf <= w_sum[DATA_W] | r_a_ovf | r_b_ovf;
        end
    end

    assign o_a     = r_a;
    assign o_a_ovf = r_a_ovf;

endmodule

`default_nettype wire

// File: rtl/seq_ctrl.sv
// ============================================================================
//  Module   : seq_ctrl
//  Brief    : Run controller streaming sequence terms over valid/ready.
//             Define SEQ_CTRL_PERF_EN to add the stall_cnt output.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module seq_ctrl
    import seq_pkg::*;
#(
    parameter int DATA_W = c_def_data_w,
    parameter int CNT_W  = c_def_cnt_w
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] cfg_seed0,
    input  logic [DATA_W-1:0] cfg_seed1,
    input  logic [CNT_W-1:0]  cfg_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_idx,
    output logic              busy,
    output logic              done,
    output logic              err_ovf
`ifdef SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [CNT_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_count;
    logic              r_done;
    logic              r_err_ovf;
    logic              w_done_set;
    logic              w_ovf_set;
    logic              w_valid;
    logic              w_busy;
    logic              w_accept;
    logic              w_xfer;
    logic              w_last;
    logic              w_step;
    logic [DATA_W-1:0] w_a;
    logic              w_a_ovf;

    seq_term_gen #(
        .DATA_W (DATA_W)
    ) u_term_gen (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_accept),
        .i_step  (w_step),
        .i_seed0 (cfg_seed0),
        .i_seed1 (cfg_seed1),
        .o_a     (w_a),
        .o_a_ovf (w_a_ovf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_done_set = 1'b0;
        w_ovf_set  = 1'b0;
        case (r_state)
            c_st_idle, c_st_done, c_st_err: begin
                if (w_accept) begin
                    w_next = c_st_load;
                end
            end
            c_st_load: begin
                if (abort) begin
                    w_next = c_st_idle;
                end else if (r_count == '0) begin
                    w_next     = c_st_done;
                    w_done_set = 1'b1;
                end else begin
                    w_next = c_st_run;
                end
            end
            c_st_run: begin
                if (abort) begin
                    w_next = c_st_idle;
                end else if (w_a_ovf) begin
                    w_next    = c_st_err;
                    w_ovf_set = 1'b1;
                end else if (w_xfer && w_last) begin
                    w_next     = c_st_done;
                    w_done_set = 1'b1;
                end
            end
            default: w_next = c_st_idle;
        endcase
    end

    // The final term does not advance the generator so DONE keeps showing it.
    always_comb begin
        w_valid  = (r_state == c_st_run) && !w_a_ovf;
        w_busy   = (r_state == c_st_load) || (r_state == c_st_run);
        w_accept = start && !abort &&
                   ((r_state == c_st_idle) || (r_state == c_st_done) || (r_state == c_st_err));
        w_xfer   = w_valid && out_ready;
        w_last   = (r_idx == r_count - CNT_W'(1));
        w_step   = w_xfer && !w_last;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx     <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_err_ovf <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (w_accept) begin
                r_count   <= cfg_count;
                r_idx     <= '0;
                r_err_ovf <= 1'b0;
            end else begin
                if (w_ovf_set) begin
                    r_err_ovf <= 1'b1;
                end
                if (w_step) begin
                    r_idx <= r_idx + CNT_W'(1);
                end
            end
        end
    end

`ifdef SEQ_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_accept) begin
            r_stall_cnt <= '0;
        end else if (w_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign out_valid = w_valid;
    assign out_data  = w_a;
    assign out_idx   = r_idx;
    assign busy      = w_busy;
    assign done      = r_done;
    assign err_ovf   = r_err_ovf;

endmodule

`default_nettype wire

// File: tb/tb_seq_ctrl.sv
// ============================================================================
//  Module   : tb_seq_ctrl
//  Brief    : Scoreboard bench for seq_ctrl with directed runs.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_ctrl;

    localparam int DW = 64;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] cfg_seed0 = '0;
    logic [DW-1:0] cfg_seed1 = '0;
    logic [CW-1:0] cfg_count = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_idx;
    logic          busy;
    logic          done;
    logic          err_ovf;
`ifdef SEQ_CTRL_PERF_EN
    logic [31:0]   stall_cnt;
`endif

    seq_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .cfg_seed0 (cfg_seed0),
        .cfg_seed1 (cfg_seed1),
        .cfg_count (cfg_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done),
        .err_ovf   (err_ovf)
`ifdef SEQ_CTRL_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  i;
    } exp_t;

    exp_t        sb[$];
    exp_t        r_e;
    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          xfer_cnt = 0;
    logic [63:0] last_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted term is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (reset) begin
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_term: got idx %0d data %0d expected no term", out_idx, out_data);
                end else begin
                    r_e = sb.pop_front();
                    chk("term_data", out_data, r_e.d);
                    chk("term_idx", 64'(out_idx), 64'(r_e.i));
                    last_data = out_data;
                    xfer_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d, input int i);
        sb.push_back(exp_t'({d, 8'(i)}));
    endtask

    task automatic start_run(input logic [63:0] s0, input logic [63:0] s1, input int c);
        cfg_seed0 = s0;
        cfg_seed1 = s1;
        cfg_count = 8'(c);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (!done && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          n;
        int          d0;
        int          x0;
        int          fibs[10];
        logic [63:0] fa;
        logic [63:0] fb;
        logic [63:0] ft;

        fibs = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err_ovf), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_idx", 64'(out_idx), 64'd0);
        reset = 1'b1;
        tick();

        // Basic run
        for (int i = 0; i < 10; i++) push(64'(fibs[i]), i);
        d0 = done_cnt;
        start_run(64'd0, 64'd1, 10);
        chk("basic_load_valid", 64'(out_valid), 64'd0);
        chk("basic_load_busy", 64'(busy), 64'd1);
        tick();
        chk("basic_first_valid", 64'(out_valid), 64'd1);
        wait_done(30, n);
        chk("basic_cycles", 64'(n), 64'd10);
        chk("basic_done", 64'(done), 64'd1);
        tick();
        chk("basic_done_pulse", 64'(done), 64'd0);
        chk("basic_busy_fall", 64'(busy), 64'd0);
        chk("basic_done_count", 64'(done_cnt - d0), 64'd1);
        chk("basic_sb_empty", 64'(sb.size()), 64'd0);

        // Overflow
        fa = 64'd0;
        fb = 64'd1;
        for (int i = 0; i < 94; i++) begin
            push(fa, i);
            ft = fa + fb;
            fa = fb;
            fb = ft;
        end
        d0 = done_cnt;
        x0 = xfer_cnt;
        start_run(64'd0, 64'd1, 100);
        n = 0;
        while (!err_ovf && !done && n < 300) begin
            tick();
            n++;
        end
        chk("ovf_err", 64'(err_ovf), 64'd1);
        chk("ovf_no_done", 64'(done_cnt - d0), 64'd0);
        chk("ovf_terms", 64'(xfer_cnt - x0), 64'd94);
        chk("ovf_last", last_data, 64'd12200160415121876738);
        chk("ovf_valid", 64'(out_valid), 64'd0);
        chk("ovf_busy", 64'(busy), 64'd0);
        chk("ovf_sb_empty", 64'(sb.size()), 64'd0);

        // Backpressure (also clears err_ovf)
        push(64'd5, 0);
        push(64'd7, 1);
        push(64'd12, 2);
        push(64'd19, 3);
        start_run(64'd5, 64'd7, 4);
        chk("bp_err_cleared", 64'(err_ovf), 64'd0);
        tick();
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_data", out_data, 64'd7);
            chk("bp_hold_idx", 64'(out_idx), 64'd1);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        wait_done(20, n);
        chk("bp_done", 64'(done), 64'd1);
        tick();
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);
`ifdef SEQ_CTRL_PERF_EN
        chk("bp_stall_cnt", 64'(stall_cnt), 64'd5);
`endif

        // Zero count
        start_run(64'd1, 64'd1, 0);
        chk("zero_load_valid", 64'(out_valid), 64'd0);
        chk("zero_load_busy", 64'(busy), 64'd1);
        tick();
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_valid", 64'(out_valid), 64'd0);
        tick();
        chk("zero_done_pulse", 64'(done), 64'd0);
        chk("zero_busy", 64'(busy), 64'd0);

        // start while busy is ignored
        push(64'd2, 0);
        push(64'd3, 1);
        push(64'd5, 2);
        push(64'd8, 3);
        push(64'd13, 4);
        push(64'd21, 5);
        start_run(64'd2, 64'd3, 6);
        tick();
        tick();
        start_run(64'd100, 64'd100, 3);
        chk("bs_busy", 64'(busy), 64'd1);
        wait_done(30, n);
        chk("bs_done", 64'(done), 64'd1);
        tick();
        chk("bs_sb_empty", 64'(sb.size()), 64'd0);
        chk("bs_final_data", out_data, 64'd21);

        // Abort at idx 3 with a simultaneous transfer
        push(64'd0, 0);
        push(64'd1, 1);
        push(64'd1, 2);
        push(64'd2, 3);
        d0 = done_cnt;
        start_run(64'd0, 64'd1, 10);
        repeat (4) tick();
        chk("ab_idx", 64'(out_idx), 64'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_valid", 64'(out_valid), 64'd0);
        chk("ab_busy", 64'(busy), 64'd0);
        chk("ab_done", 64'(done), 64'd0);
        tick();
        chk("ab_no_done", 64'(done_cnt - d0), 64'd0);
        chk("ab_sb_empty", 64'(sb.size()), 64'd0);
        cfg_count = 8'd5;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("ab_start_ignored", 64'(busy), 64'd0);
        tick();
        chk("ab_still_idle", 64'(out_valid), 64'd0);

        // Reset mid-run
        push(64'd0, 0);
        push(64'd1, 1);
        push(64'd1, 2);
        push(64'd2, 3);
        start_run(64'd0, 64'd1, 10);
        repeat (5) tick();
        chk("rm_idx", 64'(out_idx), 64'd4);
        #1;
        reset = 1'b0;
        #1;
        chk("rm_valid", 64'(out_valid), 64'd0);
        chk("rm_busy", 64'(busy), 64'd0);
        chk("rm_data", out_data, 64'd0);
        chk("rm_idx_zero", 64'(out_idx), 64'd0);
        chk("rm_done", 64'(done), 64'd0);
        chk("rm_sb_empty", 64'(sb.size()), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        push(64'd0, 0);
        push(64'd1, 1);
        push(64'd1, 2);
        start_run(64'd0, 64'd1, 3);
        tick();
        chk("rm_restart_idx", 64'(out_idx), 64'd0);
        chk("rm_restart_valid", 64'(out_valid), 64'd1);
        wait_done(20, n);
        chk("rm_restart_done", 64'(done), 64'd1);
        tick();
        chk("rm_restart_sb", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
